// File: rtl/ibuf_rd_ctrl.sv
// ----------------------------------------------------------------------------
// ibuf_rd_ctrl
//   Read-side controller for the three-bank input-buffer SRAM. A start command
//   reads `len` consecutive words from all three banks in lockstep, beginning
//   at `base_addr` (wrapping modulo 2^AW). Each three-word beat is presented on
//   a valid/ready stream. A 2-entry skid FIFO absorbs the one-cycle SRAM read
//   latency and downstream backpressure. Reads are only issued while a FIFO
//   slot is guaranteed, so returning SRAM data is never dropped.
//
// Ports
//   SYS_CLK, SYS_NRST        clock (rising edge), async active-low reset
//   start, base_addr, len    command; sampled only while idle
//   busy, done               command in progress / one-cycle completion pulse
//   CEN, WEN, A0..A2         SRAM bank controls (WEN tied to read)
//   DOUT0..DOUT2             SRAM read data, valid the cycle after CEN
//   rd_valid, rd_ready       output beat handshake
//   rd_data0..2, rd_last     output beat payload and end-of-command marker
// ----------------------------------------------------------------------------
module ibuf_rd_ctrl #(
    parameter int AW = 10,
    parameter int DW = 128
) (
    input  logic          SYS_CLK,
    input  logic          SYS_NRST,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [2:0]    CEN,
    output logic [2:0]    WEN,
    output logic [AW-1:0] A0,
    output logic [AW-1:0] A1,
    output logic [AW-1:0] A2,
    input  logic [DW-1:0] DOUT0,
    input  logic [DW-1:0] DOUT1,
    input  logic [DW-1:0] DOUT2,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data0,
    output logic [DW-1:0] rd_data1,
    output logic [DW-1:0] rd_data2,
    output logic          rd_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic [AW:0]   issued;
    logic          inflight;
    logic          inflight_last;
    logic          done_q;

    logic [DW-1:0] fifo_d0 [2];
    logic [DW-1:0] fifo_d1 [2];
    logic [DW-1:0] fifo_d2 [2];
    logic          fifo_last [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    occ;

    logic          pop;
    logic          push;
    logic          issue;
    logic          issue_last;
    logic [2:0]    credit_used;
    logic [AW-1:0] addr;

    assign rd_valid = (occ != 2'd0);
    assign pop      = rd_valid & rd_ready;
    assign push     = inflight;

    // Slots already spoken for after this cycle: stored beats plus the beat
    // returning from the SRAM, minus the beat leaving now. A new read may only
    // be issued if that leaves room for its data two cycles from now.
    assign credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue       = (state == S_READ) && (issued != len_q) && (credit_used < 3'd2);
    assign issue_last  = issue && (issued == len_q - CNT_ONE);

    // Address wraps naturally in AW bits.
    assign addr = base_q + issued[AW-1:0];
    assign CEN  = {3{issue}};
    assign WEN  = 3'b000;
    assign A0   = issue ? addr : '0;
    assign A1   = issue ? addr : '0;
    assign A2   = issue ? addr : '0;

    assign rd_data0 = fifo_d0[rd_ptr];
    assign rd_data1 = fifo_d1[rd_ptr];
    assign rd_data2 = fifo_d2[rd_ptr];
    assign rd_last  = fifo_last[rd_ptr];

    // busy falls exactly when the registered done pulse rises.
    assign busy = (state != S_IDLE);
    assign done = done_q;

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start && (len != '0)) state_nxt = S_READ;
            S_READ:  if (issue_last)           state_nxt = S_DRAIN;
            S_DRAIN: if (pop && rd_last)       state_nxt = S_IDLE;
            default:                           state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            state         <= S_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state         <= state_nxt;
            inflight      <= issue;
            inflight_last <= issue_last;
            // A zero-length command completes immediately without touching
            // the SRAM; otherwise done follows the final handshake.
            done_q        <= ((state == S_IDLE) && start && (len == '0)) ||
                             ((state == S_DRAIN) && pop && rd_last);
            if ((state == S_IDLE) && start) begin
                base_q <= base_addr;
                len_q  <= len;
                issued <= '0;
            end else if (issue) begin
                issued <= issued + CNT_ONE;
            end
        end
    end

    // Skid FIFO. Data returning from the SRAM is written the cycle after its
    // issue; the credit rule guarantees a free slot at that point.
    // NOTE: the two storage entries are reset because they drive the output
    // data ports directly, which must read zero while in reset.
    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_d0[i]   <= '0;
                fifo_d1[i]   <= '0;
                fifo_d2[i]   <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_d0[wr_ptr]   <= DOUT0;
                fifo_d1[wr_ptr]   <= DOUT1;
                fifo_d2[wr_ptr]   <= DOUT2;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_ibuf_rd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ibuf_rd_ctrl
//   Self-checking bench for ibuf_rd_ctrl. A behavioural three-bank SRAM model
//   returns preloaded random words. A negedge monitor checks every cycle
//   against the command's expected address sequence and beat sequence (pure
//   arithmetic over base/len), the outstanding-read bound, payload stability
//   under backpressure and the all-zero reset state. Scenario tasks drive
//   commands and check completion, latency and throughput.
// ----------------------------------------------------------------------------
module tb_ibuf_rd_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 128;
    localparam int DEPTH = 1 << AW;

    logic          SYS_CLK = 1'b0;
    logic          SYS_NRST = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done;
    logic [2:0]    CEN, WEN;
    logic [AW-1:0] A0, A1, A2;
    logic [DW-1:0] DOUT0, DOUT1, DOUT2;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic [DW-1:0] rd_data0, rd_data1, rd_data2;
    logic          rd_last;

    ibuf_rd_ctrl #(.AW(AW), .DW(DW)) dut (
        .SYS_CLK   (SYS_CLK),
        .SYS_NRST  (SYS_NRST),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .CEN       (CEN),
        .WEN       (WEN),
        .A0        (A0),
        .A1        (A1),
        .A2        (A2),
        .DOUT0     (DOUT0),
        .DOUT1     (DOUT1),
        .DOUT2     (DOUT2),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data0  (rd_data0),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_last   (rd_last)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    // ---------------- SRAM model: registered read, one cycle latency -------
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];

    always @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            DOUT0 <= '0;
            DOUT1 <= '0;
            DOUT2 <= '0;
        end else begin
            if (CEN[0]) DOUT0 <= mem0[A0];
            if (CEN[1]) DOUT1 <= mem1[A1];
            if (CEN[2]) DOUT2 <= mem2[A2];
        end
    end

    // ---------------- reference model state --------------------------------
    int n_checks = 0;
    int n_errors = 0;

    int cmd_base = 0;
    int cmd_len  = 0;
    int iss_cnt, pop_cnt, done_cnt;
    int mcyc = 0;
    int first_cen, first_valid, first_pop, last_pop, done_cyc;
    bit busy_seen;
    bit held = 1'b0;
    logic [DW-1:0] h0, h1, h2;
    logic          h_last;

    function automatic logic [AW-1:0] exp_addr(input int i);
        int a;
        a = (cmd_base + i) % DEPTH;
        return a[AW-1:0];
    endfunction

    task automatic new_cmd(input int b, input int l);
        cmd_base    = b;
        cmd_len     = l;
        iss_cnt     = 0;
        pop_cnt     = 0;
        done_cnt    = 0;
        first_cen   = -1;
        first_valid = -1;
        first_pop   = -1;
        last_pop    = -1;
        done_cyc    = -1;
        busy_seen   = 1'b0;
    endtask

    // ---------------- cycle monitor ----------------------------------------
    always @(negedge SYS_CLK) begin
        mcyc++;
        if (!SYS_NRST) begin
            n_checks++;
            if ({busy, done, CEN, WEN, A0, A1, A2, rd_valid, rd_last,
                 rd_data0, rd_data1, rd_data2} !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs: busy=%b done=%b CEN=%b A0=%h rd_valid=%b rd_last=%b, required all zero",
                         busy, done, CEN, A0, rd_valid, rd_last);
            end
            iss_cnt = 0;
            pop_cnt = 0;
            held    = 1'b0;
        end else begin
            n_checks++;
            if (WEN !== 3'b000) begin
                n_errors++;
                $display("FAIL wen: got %b required 000", WEN);
            end
            if (busy) busy_seen = 1'b1;

            if (CEN !== 3'b000) begin
                n_checks++;
                if (iss_cnt >= cmd_len) begin
                    n_errors++;
                    $display("FAIL extra_read: CEN=%b A0=%h after %0d reads, required %0d reads",
                             CEN, A0, iss_cnt, cmd_len);
                end else if (CEN !== 3'b111 || A0 !== exp_addr(iss_cnt) ||
                             A1 !== exp_addr(iss_cnt) || A2 !== exp_addr(iss_cnt)) begin
                    n_errors++;
                    $display("FAIL read_addr: read %0d got CEN=%b A=%h/%h/%h required 111 A=%h",
                             iss_cnt, CEN, A0, A1, A2, exp_addr(iss_cnt));
                end
                if (first_cen < 0) first_cen = mcyc;
                iss_cnt++;
            end

            if (rd_valid === 1'b1 && first_valid < 0) first_valid = mcyc;

            if (held) begin
                n_checks++;
                if (rd_valid !== 1'b1 || rd_data0 !== h0 || rd_data1 !== h1 ||
                    rd_data2 !== h2 || rd_last !== h_last) begin
                    n_errors++;
                    $display("FAIL stall_stable: beat %0d valid=%b d0=%h, required valid=1 d0=%h",
                             pop_cnt, rd_valid, rd_data0, h0);
                end
            end

            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                n_checks++;
                if (pop_cnt >= cmd_len) begin
                    n_errors++;
                    $display("FAIL extra_beat: beat %0d d0=%h, required only %0d beats",
                             pop_cnt, rd_data0, cmd_len);
                end else if (rd_data0 !== mem0[exp_addr(pop_cnt)] ||
                             rd_data1 !== mem1[exp_addr(pop_cnt)] ||
                             rd_data2 !== mem2[exp_addr(pop_cnt)] ||
                             rd_last !== (pop_cnt == cmd_len - 1)) begin
                    n_errors++;
                    $display("FAIL beat_data: beat %0d got d0=%h last=%b required d0=%h last=%b",
                             pop_cnt, rd_data0, rd_last, mem0[exp_addr(pop_cnt)],
                             (pop_cnt == cmd_len - 1));
                end
                if (first_pop < 0) first_pop = mcyc;
                last_pop = mcyc;
                pop_cnt++;
            end

            // Reads issued but not yet consumed can never exceed the 2 slots.
            n_checks++;
            if (iss_cnt - pop_cnt > 2) begin
                n_errors++;
                $display("FAIL credit: outstanding %0d required at most 2", iss_cnt - pop_cnt);
            end

            held   = (rd_valid === 1'b1) && (rd_ready !== 1'b1);
            h0     = rd_data0;
            h1     = rd_data1;
            h2     = rd_data2;
            h_last = rd_last;

            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = mcyc;
                n_checks++;
                if (busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL done_busy: busy=%b with done, required 0", busy);
                end
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic issue_start(input int b, input int l);
        @(posedge SYS_CLK); #1;
        new_cmd(b, l);
        start     = 1'b1;
        base_addr = b[AW-1:0];
        len       = l[AW:0];
        @(posedge SYS_CLK); #1;
        start     = 1'b0;
        base_addr = $urandom_range(0, DEPTH - 1);
        len       = $urandom_range(0, DEPTH);
        n_checks++;
        if (l != 0 && (busy !== 1'b1 || done !== 1'b0)) begin
            n_errors++;
            $display("FAIL start_busy: busy=%b done=%b required busy=1 done=0", busy, done);
        end else if (l == 0 && (busy !== 1'b0 || done !== 1'b1)) begin
            n_errors++;
            $display("FAIL len0_done: busy=%b done=%b required busy=0 done=1", busy, done);
        end
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0,1, 2: random ready.
    // inject: pulse a second start while busy, which must be ignored.
    task automatic wait_done(input int mode, input int budget, input bit inject);
        int k;
        bit got;
        got = 1'b0;
        for (k = 0; k < budget; k++) begin
            if (done_cnt != 0) begin
                got = 1'b1;
                break;
            end
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (k % 4 == 0) || (k % 4 == 3);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            start = inject && (k == 2);
            if (start) begin
                base_addr = 10'h200;
                len       = 11'd5;
            end
            @(posedge SYS_CLK); #1;
        end
        start    = 1'b0;
        rd_ready = 1'b1;
        if (!got && done_cnt != 0) got = 1'b1;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL done_timeout: no done within %0d cycles, required one", budget);
        end
        repeat (4) @(posedge SYS_CLK);
        #1;
    endtask

    task automatic check_cmd_end(input string name);
        n_checks++;
        if (iss_cnt != cmd_len || pop_cnt != cmd_len || done_cnt != 1) begin
            n_errors++;
            $display("FAIL %s_counts: reads=%0d beats=%0d dones=%0d required %0d/%0d/1",
                     name, iss_cnt, pop_cnt, done_cnt, cmd_len, cmd_len);
        end
        if (cmd_len != 0) begin
            n_checks++;
            if (done_cyc != last_pop + 1) begin
                n_errors++;
                $display("FAIL %s_done_timing: done at %0d required %0d",
                         name, done_cyc, last_pop + 1);
            end
        end
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        new_cmd(0, 0);
        SYS_NRST = 1'b0;
        repeat (3) @(posedge SYS_CLK);
        #1;
        SYS_NRST = 1'b1;
        repeat (2) @(posedge SYS_CLK);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || CEN !== 3'b000 || rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b CEN=%b valid=%b required all 0",
                     busy, done, CEN, rd_valid);
        end
    endtask

    task automatic test_basic();
        issue_start(32'h010, 4);
        wait_done(0, 40, 1'b0);
        check_cmd_end("basic");
        n_checks++;
        if (first_valid - first_cen != 2) begin
            n_errors++;
            $display("FAIL basic_latency: valid %0d cycles after issue, required 2",
                     first_valid - first_cen);
        end
        n_checks++;
        if (last_pop - first_pop != 3) begin
            n_errors++;
            $display("FAIL basic_throughput: 4 beats span %0d cycles, required 3",
                     last_pop - first_pop);
        end
    endtask

    task automatic test_wrap();
        issue_start(32'h3FE, 4);
        wait_done(0, 40, 1'b0);
        check_cmd_end("wrap");
    endtask

    task automatic test_backpressure();
        issue_start(int'($urandom_range(0, DEPTH - 1)), 8);
        wait_done(1, 100, 1'b0);
        check_cmd_end("backpressure");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            issue_start(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)));
            wait_done(2, 400, 1'b0);
            check_cmd_end("random");
        end
    endtask

    task automatic test_len0_and_busy_start();
        issue_start(32'h055, 0);
        wait_done(0, 10, 1'b0);
        check_cmd_end("len0");
        n_checks++;
        if (busy_seen) begin
            n_errors++;
            $display("FAIL len0_busy: busy asserted, required never");
        end
        issue_start(32'h123, 6);
        wait_done(0, 40, 1'b1);
        check_cmd_end("busy_start");
    endtask

    task automatic test_reset_mid();
        int k;
        issue_start(32'h2A0, 6);
        rd_ready = 1'b1;
        for (k = 0; k < 40 && pop_cnt < 3; k++) begin
            @(posedge SYS_CLK); #1;
        end
        n_checks++;
        if (pop_cnt < 3) begin
            n_errors++;
            $display("FAIL mid_progress: %0d beats before reset, required 3", pop_cnt);
        end
        SYS_NRST = 1'b0;
        cmd_len  = 0;
        repeat (3) @(posedge SYS_CLK);
        #1;
        SYS_NRST = 1'b1;
        repeat (5) @(posedge SYS_CLK);
        #1;
        n_checks++;
        if (done_cnt != 0 || iss_cnt != 0 || pop_cnt != 0) begin
            n_errors++;
            $display("FAIL mid_abandon: dones=%0d reads=%0d beats=%0d after reset, required 0/0/0",
                     done_cnt, iss_cnt, pop_cnt);
        end
        issue_start(32'h100, 2);
        wait_done(0, 40, 1'b0);
        check_cmd_end("after_reset");
    endtask

    task automatic test_full();
        issue_start(int'($urandom_range(0, DEPTH - 1)), DEPTH);
        wait_done(0, DEPTH + 40, 1'b0);
        check_cmd_end("full");
        n_checks++;
        if (last_pop - first_pop != DEPTH - 1) begin
            n_errors++;
            $display("FAIL full_throughput: %0d beats span %0d cycles, required %0d",
                     DEPTH, last_pop - first_pop, DEPTH - 1);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = {$urandom, $urandom, $urandom, $urandom};
            mem1[i] = {$urandom, $urandom, $urandom, $urandom};
            mem2[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        new_cmd(0, 0);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_random();
        test_len0_and_busy_start();
        test_reset_mid();
        test_full();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ibuf_rd_ctrl.md
Name: ibuf_rd_ctrl

Overview:
- Read-side controller for the three-bank input-buffer SRAM (three banks, each AW x DW, single-cycle registered read).
- On a start command, reads `len` consecutive words from all three banks in lockstep, starting at `base_addr`.
- Presents each three-row beat (one word per bank) on a valid/ready stream to the downstream convolution datapath.
- Absorbs the SRAM read latency and downstream backpressure with a 2-entry skid FIFO, so SRAM data is never lost.

Parameters:
- AW, 10, SRAM address width per bank.
- DW, 128, SRAM data width per bank.

Ports:
- SYS_CLK  in  1  system clock, rising edge.
- SYS_NRST  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  in  AW  first word address, common to all banks; sampled with start.
- len  in  AW+1  number of beats, 0..2^AW; sampled with start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of command.
- CEN  out  3  per-bank chip enable, active high.
- WEN  out  3  per-bank write enable, active high; always 3'b000.
- A0, A1, A2  out  AW each  bank addresses; always identical.
- DOUT0, DOUT1, DOUT2  in  DW each  bank read data, valid the cycle after CEN.
- rd_valid  out  1  beat available.
- rd_ready  in  1  downstream accepts beat.
- rd_data0, rd_data1, rd_data2  out  DW each  bank 0/1/2 word of current beat.
- rd_last  out  1  current beat is the final beat of the command.

Behaviour:
- Reset (async, SYS_NRST low):
  - FSM to IDLE; issue/return counters and FIFO cleared.
  - All outputs 0: busy, done, CEN, WEN, A0..A2, rd_valid, rd_data*, rd_last.
  - Reset mid-command abandons the command; in-flight SRAM data is discarded and no done is produced.
- FSM states:
  - IDLE -> READ on start with len != 0; latch base_addr, len; busy=1 next cycle.
  - IDLE, start with len == 0: no SRAM access; done pulses next cycle; busy stays 0.
  - READ: issue reads until issued count == len -> DRAIN.
  - DRAIN: wait until the last beat handshakes (rd_valid & rd_ready & rd_last) -> IDLE. done=1 on the cycle after that handshake; busy falls in the same cycle.
  - start while busy is ignored.
- Read issue:
  - A read is issued in a cycle when: FSM in READ, issued < len, and (fifo_occ + inflight - pop) < 2, where pop = rd_valid & rd_ready.
  - An issue drives CEN=3'b111 combinationally, with A0=A1=A2=base+issued, modulo 2^AW (wraps 2^AW-1 -> 0).
  - CEN=3'b000 on every cycle without an issue.
  - inflight = 1 in the cycle after an issue. DOUT0..2 are captured into the FIFO at the end of that cycle.
- Latency and throughput:
  - Issue at cycle t -> rd_valid at t+2 if the FIFO was empty.
  - With rd_ready held high: one beat per cycle sustained, no bubbles after the first.
- FIFO and output stream:
  - 2 entries x (3*DW + last). Head drives rd_data*/rd_last.
  - rd_data*/rd_last hold stable while rd_valid & !rd_ready.
  - Simultaneous push and pop is legal at any occupancy permitted by the credit rule; the FIFO never overflows.
  - Beats emerge in address order.
- rd_last = 1 only on beat index len-1.
- len = 2^AW: reads every address once, starting at base_addr and wrapping.

Test Plan:
- base_addr=0x010, len=4, rd_ready=1 → A = 0x010..0x013 on 4 consecutive cycles with CEN=111; rd_data* = preloaded words at t+2..t+5; rd_last on 4th beat; done one cycle after; WEN=000 throughout.
- base_addr=0x3FE, len=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001; data order matches.
- len=8, rd_ready toggling 1,0,0,1 pattern → issue stalls when fifo_occ+inflight reaches 2; all 8 beats delivered in order; no beat lost or duplicated; rd_data stable while stalled.
- len=0 start → no CEN activity; done pulses next cycle; busy never asserts. A second start while busy → ignored, no extra reads.
- SYS_NRST asserted after 3 of 6 beats, then released; new start base=0x100, len=2 → outputs 0 during reset; only the 2 new beats appear; single done.
- len=1024, rd_ready=1 → exactly 1024 beats, 1024 CEN cycles, one done, rd_last on beat 1023.
